wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two sources:
  - the in-order pipeline writeback, taken from the MEM/WB register outputs after the Mem2Reg mux;
  - a long-latency unit (LLU), e.g. a multi-cycle mul/div, which uses a valid/ready handshake.
- Pipeline writeback has priority.
- A starvation counter briefly freezes the pipeline so the LLU cannot wait forever.
- Sits between the MEM/WB register, the LLU and the register file.

---
 rtl/wb_port_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority; a starvation counter forces one LLU slot.
// Optional statistics outputs (force_count, llu_wait_max) are enabled with WB_ARB_STATS_EN.
//
// state  | meaning
// NORMAL | WB owns the port when requesting, otherwise the LLU may write
// FORCE  | one-cycle pipeline freeze, port reserved for the LLU
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_data,
    input  logic             llu_valid,
    input  logic [4:0]       llu_rd,
    input  logic [31:0]      llu_data,
    output logic             llu_ready,
    output logic             stall_pipe,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]      force_count,
    output logic [CNT_W-1:0] llu_wait_max
`endif
);

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wb_req;
    logic             grant_wb;
    logic             llu_hs;
    logic             llu_wr;

    assign wb_req     = wb_regwrite && (wb_rd != 5'd0);
    assign llu_hs     = llu_valid && llu_ready;
    assign llu_wr     = llu_hs && (llu_rd != 5'd0);
    assign stall_pipe = (state == FORCE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        llu_ready = 1'b0;
        grant_wb  = 1'b0;
        case (state)
            NORMAL: begin
                grant_wb  = wb_req;
                llu_ready = !wb_req;
                // The LLU is blocked exactly when it is valid and WB holds the port.
                if (llu_valid && wb_req) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt_nxt == LIMIT) begin
                        state_nxt = FORCE;
                    end
                end
            end
            FORCE: begin
                llu_ready = 1'b1;
                state_nxt = NORMAL;
            end
            default: begin
                state_nxt = NORMAL;
            end
        endcase
        if (!reset_n) begin
            llu_ready = 1'b0;
            grant_wb  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= NORMAL;
            cnt      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rf_we <= grant_wb || llu_wr;
            if (grant_wb) begin
                rf_waddr <= wb_rd;
                rf_wdata <= wb_data;
            end else if (llu_wr) begin
                rf_waddr <= llu_rd;
                rf_wdata <= llu_data;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            force_count  <= 16'd0;
            llu_wait_max <= '0;
        end else begin
            if (state == FORCE && force_count != 16'hFFFF) begin
                force_count <= force_count + 16'd1;
            end
            if (cnt > llu_wait_max) begin
                llu_wait_max <= cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter at STARVE_LIMIT=4.
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        llu_valid;
    logic [4:0]  llu_rd;
    logic [31:0] llu_data;
    logic        llu_ready;
    logic        stall_pipe;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_ARB_STATS_EN
    logic [15:0] force_count;
    logic [3:0]  llu_wait_max;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .llu_valid   (llu_valid),
        .llu_rd      (llu_rd),
        .llu_data    (llu_data),
        .llu_ready   (llu_ready),
        .stall_pipe  (stall_pipe),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
`ifdef WB_ARB_STATS_EN
        ,
        .force_count (force_count),
        .llu_wait_max(llu_wait_max)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [4:0] wrd, input logic [31:0] wdat,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        wb_regwrite = wr;
        wb_rd       = wrd;
        wb_data     = wdat;
        llu_valid   = lv;
        llu_rd      = lrd;
        llu_data    = ldat;
        #1;
    endtask

    // One arbitration cycle: check combinational outputs, then the write it produces.
    task automatic cycle(input string tag, input logic exp_ready, input logic exp_stall,
                         input logic exp_we, input logic [4:0] exp_addr, input logic [31:0] exp_data);
        chk({tag, ".ready"}, 32'(llu_ready), 32'(exp_ready));
        chk({tag, ".stall"}, 32'(stall_pipe), 32'(exp_stall));
        tick();
        chk({tag, ".we"}, 32'(rf_we), 32'(exp_we));
        chk({tag, ".addr"}, 32'(rf_waddr), 32'(exp_addr));
        chk({tag, ".data"}, rf_wdata, exp_data);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b1, 5'd5, 32'd55, 1'b1, 5'd9, 32'd99);
        chk("rst0.ready", 32'(llu_ready), 32'd0);
        tick();
        chk("rst1.we", 32'(rf_we), 32'd0);
        chk("rst1.stall", 32'(stall_pipe), 32'd0);
        chk("rst1.ready", 32'(llu_ready), 32'd0);
        tick();
        chk("rst2.we", 32'(rf_we), 32'd0);
        chk("rst2.addr", 32'(rf_waddr), 32'd0);
        chk("rst2.data", rf_wdata, 32'd0);
        chk("rst2.stall", 32'(stall_pipe), 32'd0);
        chk("rst2.ready", 32'(llu_ready), 32'd0);

        // Release: WB wins first, the still-valid LLU is served once the pipeline goes quiet.
        reset_n = 1'b1;
        #1;
        cycle("rel_wb", 1'b0, 1'b0, 1'b1, 5'd5, 32'd55);
        drive(1'b0, 5'd5, 32'd55, 1'b1, 5'd9, 32'd99);
        cycle("rel_llu", 1'b1, 1'b0, 1'b1, 5'd9, 32'd99);

        drive(1'b1, 5'd20, 32'd500, 1'b0, 5'd9, 32'd99);
        cycle("wb_only", 1'b0, 1'b0, 1'b1, 5'd20, 32'd500);

        drive(1'b0, 5'd20, 32'd500, 1'b1, 5'd7, 32'hDEAD);
        cycle("idle_llu", 1'b1, 1'b0, 1'b1, 5'd7, 32'hDEAD);

        drive(1'b0, 5'd20, 32'd500, 1'b0, 5'd7, 32'hDEAD);
        cycle("no_grant", 1'b1, 1'b0, 1'b0, 5'd7, 32'hDEAD);

        drive(1'b1, 5'd0, 32'd123, 1'b1, 5'd3, 32'd333);
        cycle("x0_wb", 1'b1, 1'b0, 1'b1, 5'd3, 32'd333);

        drive(1'b0, 5'd0, 32'd123, 1'b1, 5'd0, 32'd444);
        cycle("x0_llu", 1'b1, 1'b0, 1'b0, 5'd3, 32'd333);

        // Starvation: four blocked cycles, one FORCE cycle writing r9, then the held WB r5.
        drive(1'b1, 5'd1, 32'd101, 1'b1, 5'd9, 32'd900);
        cycle("stv1", 1'b0, 1'b0, 1'b1, 5'd1, 32'd101);
        drive(1'b1, 5'd2, 32'd102, 1'b1, 5'd9, 32'd900);
        cycle("stv2", 1'b0, 1'b0, 1'b1, 5'd2, 32'd102);
        drive(1'b1, 5'd3, 32'd103, 1'b1, 5'd9, 32'd900);
        cycle("stv3", 1'b0, 1'b0, 1'b1, 5'd3, 32'd103);
        drive(1'b1, 5'd4, 32'd104, 1'b1, 5'd9, 32'd900);
        cycle("stv4", 1'b0, 1'b0, 1'b1, 5'd4, 32'd104);
        drive(1'b1, 5'd5, 32'd105, 1'b1, 5'd9, 32'd900);
        cycle("stv_force", 1'b1, 1'b1, 1'b1, 5'd9, 32'd900);
        drive(1'b1, 5'd5, 32'd105, 1'b0, 5'd9, 32'd900);
        cycle("stv_held", 1'b0, 1'b0, 1'b1, 5'd5, 32'd105);
        drive(1'b0, 5'd5, 32'd105, 1'b0, 5'd9, 32'd900);
        cycle("stv_idle", 1'b1, 1'b0, 1'b0, 5'd5, 32'd105);

        // Reset mid-wait: counter at 3 is discarded, four fresh blocked cycles precede FORCE.
        drive(1'b1, 5'd10, 32'd210, 1'b1, 5'd11, 32'd1111);
        cycle("rmw1", 1'b0, 1'b0, 1'b1, 5'd10, 32'd210);
        drive(1'b1, 5'd12, 32'd212, 1'b1, 5'd11, 32'd1111);
        cycle("rmw2", 1'b0, 1'b0, 1'b1, 5'd12, 32'd212);
        drive(1'b1, 5'd13, 32'd213, 1'b1, 5'd11, 32'd1111);
        cycle("rmw3", 1'b0, 1'b0, 1'b1, 5'd13, 32'd213);
        reset_n = 1'b0;
        drive(1'b1, 5'd14, 32'd214, 1'b1, 5'd11, 32'd1111);
        cycle("rmw_rst", 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        reset_n = 1'b1;
        drive(1'b1, 5'd14, 32'd214, 1'b1, 5'd11, 32'd1111);
        cycle("rmw_a", 1'b0, 1'b0, 1'b1, 5'd14, 32'd214);
        drive(1'b1, 5'd15, 32'd215, 1'b1, 5'd11, 32'd1111);
        cycle("rmw_b", 1'b0, 1'b0, 1'b1, 5'd15, 32'd215);
        drive(1'b1, 5'd16, 32'd216, 1'b1, 5'd11, 32'd1111);
        cycle("rmw_c", 1'b0, 1'b0, 1'b1, 5'd16, 32'd216);
        drive(1'b1, 5'd17, 32'd217, 1'b1, 5'd11, 32'd1111);
        cycle("rmw_d", 1'b0, 1'b0, 1'b1, 5'd17, 32'd217);
        drive(1'b1, 5'd18, 32'd218, 1'b1, 5'd11, 32'd1111);
        cycle("rmw_force", 1'b1, 1'b1, 1'b1, 5'd11, 32'd1111);
        drive(1'b1, 5'd18, 32'd218, 1'b0, 5'd11, 32'd1111);
        cycle("rmw_held", 1'b0, 1'b0, 1'b1, 5'd18, 32'd218);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
